background_renderer: RTL and testbench

Parametrised, pipelined successor to the single-cycle background colouring block. For each pixel coordinate from the VGA controller it classifies the pixel as path, inner banner, outer banner or field, and looks up a per-level palette colour. It adds a frame-stepped fade-out/fade-in state machine for level transitions. It sits between the VGA coordinate generator and the sprite/tower compositing mux.

---
 rtl/bg_pkg.sv | 88 ++++++++
 rtl/bg_region_classify.sv | 31 +++
 rtl/background_renderer.sv | 181 ++++++++++++++++++
 tb/tb_background_renderer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/bg_pkg.sv
// Shared types, geometry and colour tables for the background renderer.
package bg_pkg;

  // Pixel classification, listed in priority order (highest first).
  typedef enum logic [1:0] {
    PATH       = 2'd0,
    BANNER_IN  = 2'd1,
    BANNER_OUT = 2'd2,
    FIELD      = 2'd3
  } region_t;

  // Level-transition fade controller states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_OUT = 2'd1,
    FADE_IN  = 2'd2
  } fade_state_t;

  // Axis-aligned rectangle, all bounds inclusive.
  typedef struct packed {
    logic [9:0] x0;
    logic [9:0] x1;
    logic [9:0] y0;
    logic [9:0] y1;
  } rect_t;

  // Enemy path: a snake of horizontal and vertical segments across the field.
  localparam int NUM_PATH_RECTS = 7;
  localparam rect_t PATH_RECTS [NUM_PATH_RECTS] = '{
    '{10'd0,   10'd120, 10'd280, 10'd320},
    '{10'd80,  10'd120, 10'd120, 10'd320},
    '{10'd80,  10'd320, 10'd120, 10'd160},
    '{10'd280, 10'd320, 10'd120, 10'd420},
    '{10'd280, 10'd520, 10'd380, 10'd420},
    '{10'd480, 10'd520, 10'd200, 10'd420},
    '{10'd480, 10'd639, 10'd200, 10'd240}
  };

  // Banner geometry: two end caps joined by a band along the top edge.
  localparam logic [9:0]  INNER_CX_L  = 10'd100;
  localparam logic [9:0]  INNER_CX_R  = 10'd540;
  localparam logic [22:0] INNER_R2    = 23'd2500;
  localparam logic [9:0]  INNER_Y_MAX = 10'd50;
  localparam logic [9:0]  OUTER_CX_L  = 10'd70;
  localparam logic [9:0]  OUTER_CX_R  = 10'd570;
  localparam logic [22:0] OUTER_R2    = 23'd6400;
  localparam logic [9:0]  OUTER_Y_MAX = 10'd80;

  // Fixed colours and the per-level field palette.
  localparam logic [23:0] COLOUR_PATH       = 24'h808080;
  localparam logic [23:0] COLOUR_BANNER_IN  = 24'he9bf2f;
  localparam logic [23:0] COLOUR_BANNER_OUT = 24'hfdeca6;
  localparam logic [23:0] COLOUR_NO_LEVEL   = 24'hffffff;
  localparam int NUM_PALETTE = 3;
  localparam logic [23:0] FIELD_PALETTE [NUM_PALETTE] = '{
    24'ha6e0fd, 24'hc0c0c0, 24'h0ed145
  };

  function automatic logic in_rect(input logic [9:0] x, input logic [9:0] y, input rect_t r);
    return (x >= r.x0) && (x <= r.x1) && (y >= r.y0) && (y <= r.y1);
  endfunction

  // Distance test uses a signed X difference so points left of the centre
  // square correctly instead of wrapping to a huge unsigned value.
  function automatic logic in_circle(input logic [9:0] x, input logic [9:0] y,
                                     input logic [9:0] cx, input logic [22:0] r2);
    logic signed [10:0] dx;
    logic signed [21:0] dx_ext;
    logic signed [21:0] dx_sq;
    logic        [19:0] dy_sq;
    logic        [22:0] dist2;
    dx     = $signed({1'b0, x}) - $signed({1'b0, cx});
    dx_ext = 22'(dx);
    dx_sq  = dx_ext * dx_ext;
    dy_sq  = {10'd0, y} * {10'd0, y};
    dist2  = {1'b0, $unsigned(dx_sq)} + {3'd0, dy_sq};
    return dist2 <= r2;
  endfunction

  // Banner shape: left cap, right cap, or the band between the centres.
  function automatic logic in_banner(input logic [9:0] x, input logic [9:0] y,
                                     input logic [9:0] cx_l, input logic [9:0] cx_r,
                                     input logic [22:0] r2, input logic [9:0] y_max);
    return in_circle(x, y, cx_l, r2) || in_circle(x, y, cx_r, r2) ||
           ((x >= cx_l) && (x <= cx_r) && (y <= y_max));
  endfunction

endpackage

// File: rtl/bg_region_classify.sv
// Combinational pixel classifier: coordinate in, region class out.
module bg_region_classify
  import bg_pkg::*;
#(
  parameter int NUM_RECTS = 7
) (
  input  logic [9:0] draw_x_i,
  input  logic [9:0] draw_y_i,
  output region_t    region_o
);

  logic [NUM_RECTS-1:0] rect_hit;
  logic                 inner_hit;
  logic                 outer_hit;

  for (genvar gi = 0; gi < NUM_RECTS; gi++) begin : g_rect
    assign rect_hit[gi] = in_rect(draw_x_i, draw_y_i, PATH_RECTS[gi]);
  end

  assign inner_hit = in_banner(draw_x_i, draw_y_i, INNER_CX_L, INNER_CX_R, INNER_R2, INNER_Y_MAX);
  assign outer_hit = in_banner(draw_x_i, draw_y_i, OUTER_CX_L, OUTER_CX_R, OUTER_R2, OUTER_Y_MAX);

  // Priority resolve: path over inner banner over outer banner over field.
  always_comb begin
    region_o = FIELD;
    if (|rect_hit)      region_o = PATH;
    else if (inner_hit) region_o = BANNER_IN;
    else if (outer_hit) region_o = BANNER_OUT;
  end

endmodule

// File: rtl/background_renderer.sv
// Two-stage background colour pipeline with a frame-stepped level fade.
module background_renderer
  import bg_pkg::*;
#(
  parameter int LVL_W           = 3,
  parameter int NUM_LEVELS      = 3,
  parameter int NUM_RECTS       = 7,
  parameter int ALPHA_W         = 4,
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  input  logic             pix_valid_in,
  input  logic             frame_start,
  input  logic [LVL_W-1:0] level_index,
  output logic [23:0]      data_Out_background,
  output logic             pix_valid_out,
  output logic             fade_busy,
  output logic [LVL_W-1:0] level_active
);

  localparam logic [ALPHA_W:0] ALPHA_FULL = (ALPHA_W + 1)'(2 ** ALPHA_W);
  localparam logic [ALPHA_W:0] ALPHA_ONE  = (ALPHA_W + 1)'(1);
  localparam int CNT_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int PROD_W = 8 + ALPHA_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

  // Fade controller state
  fade_state_t      state_q;
  logic [ALPHA_W:0] alpha_q;
  logic [CNT_W-1:0] frame_cnt_q;
  logic [LVL_W-1:0] target_q;
  logic [LVL_W-1:0] level_q;
  logic             busy_q;
  logic             step_now;

  // Pipeline state
  region_t          region_s1_q;
  logic [LVL_W-1:0] level_s1_q;
  logic             valid_s1_q;
  logic [23:0]      colour_s2_q;
  logic             valid_s2_q;

  region_t          region_c;
  logic [23:0]      field_colour;
  logic [23:0]      base_colour;
  logic [23:0]      scaled_colour;

  assign step_now = frame_start && (frame_cnt_q == CNT_LAST);

  // Fade FSM: alpha only moves on counted frame_start pulses, so level_active
  // switches at vertical blank and a frame never mixes two levels.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      alpha_q     <= ALPHA_FULL;
      frame_cnt_q <= '0;
      target_q    <= '0;
      level_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          alpha_q     <= ALPHA_FULL;
          frame_cnt_q <= '0;
          if (level_index != level_q) begin
            target_q <= level_index;
            state_q  <= FADE_OUT;
            busy_q   <= 1'b1;
          end
        end
        FADE_OUT: begin
          // Latest request wins; the dim-down keeps going regardless.
          target_q <= level_index;
          if (frame_start) begin
            if (step_now) begin
              frame_cnt_q <= '0;
              alpha_q     <= alpha_q - ALPHA_ONE;
              if (alpha_q == ALPHA_ONE) begin
                level_q <= target_q;
                state_q <= FADE_IN;
              end
            end else begin
              frame_cnt_q <= frame_cnt_q + 1'b1;
            end
          end
        end
        FADE_IN: begin
          if (level_index != level_q) begin
            // Reverse direction from the current alpha; no brightness jump.
            target_q    <= level_index;
            frame_cnt_q <= '0;
            state_q     <= FADE_OUT;
          end else if (frame_start) begin
            if (step_now) begin
              frame_cnt_q <= '0;
              alpha_q     <= alpha_q + ALPHA_ONE;
              if (alpha_q == ALPHA_FULL - ALPHA_ONE) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              frame_cnt_q <= frame_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          alpha_q     <= ALPHA_FULL;
          frame_cnt_q <= '0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  bg_region_classify #(
    .NUM_RECTS(NUM_RECTS)
  ) u_classify (
    .draw_x_i(DrawX),
    .draw_y_i(DrawY),
    .region_o(region_c)
  );

  // Stage 1: capture region class, the level it belongs to, and valid.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      region_s1_q <= PATH;
      level_s1_q  <= '0;
      valid_s1_q  <= 1'b0;
    end else begin
      region_s1_q <= region_c;
      level_s1_q  <= level_q;
      valid_s1_q  <= pix_valid_in;
    end
  end

  // Field palette lookup; levels outside the palette render white.
  always_comb begin
    field_colour = COLOUR_NO_LEVEL;
    for (int i = 0; i < NUM_PALETTE; i++) begin
      if ((i < NUM_LEVELS) && (level_s1_q == LVL_W'(i))) field_colour = FIELD_PALETTE[i];
    end
  end

  // Pick the unfaded colour for the stage-1 region.
  always_comb begin
    base_colour = field_colour;
    case (region_s1_q)
      PATH:       base_colour = COLOUR_PATH;
      BANNER_IN:  base_colour = COLOUR_BANNER_IN;
      BANNER_OUT: base_colour = COLOUR_BANNER_OUT;
      default:    base_colour = field_colour;
    endcase
  end

  // Per-channel alpha scale: (c * alpha) >> ALPHA_W, identity at full alpha.
  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    assign scaled_colour[gi*8 +: 8] =
      8'((PROD_W'(base_colour[gi*8 +: 8]) * PROD_W'(alpha_q)) >> ALPHA_W);
  end

  // Stage 2: register the faded colour and valid.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      colour_s2_q <= 24'h000000;
      valid_s2_q  <= 1'b0;
    end else begin
      colour_s2_q <= scaled_colour;
      valid_s2_q  <= valid_s1_q;
    end
  end

  assign data_Out_background = colour_s2_q;
  assign pix_valid_out       = valid_s2_q;
  assign fade_busy           = busy_q;
  assign level_active        = level_q;

endmodule

// File: tb/tb_background_renderer.sv
// Directed self-checking bench for background_renderer.
module tb_background_renderer;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        pix_valid_in;
  logic        frame_start;
  logic [2:0]  level_index;
  logic [23:0] data_Out_background;
  logic        pix_valid_out;
  logic        fade_busy;
  logic [2:0]  level_active;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  background_renderer #(
    .LVL_W(3), .NUM_LEVELS(3), .NUM_RECTS(7), .ALPHA_W(4), .FRAMES_PER_STEP(2)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .DrawX(DrawX),
    .DrawY(DrawY),
    .pix_valid_in(pix_valid_in),
    .frame_start(frame_start),
    .level_index(level_index),
    .data_Out_background(data_Out_background),
    .pix_valid_out(pix_valid_out),
    .fade_busy(fade_busy),
    .level_active(level_active)
  );

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: got %h", tag, got);
    end
  endtask

  // Present one pixel and wait out the two-cycle latency.
  task automatic check_pixel(input string tag, input logic [9:0] x, input logic [9:0] y,
                             input logic [23:0] exp);
    @(negedge Clk);
    DrawX = x;
    DrawY = y;
    pix_valid_in = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    check(tag, data_Out_background, exp);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      frame_start = 1'b1;
      @(negedge Clk);
      frame_start = 1'b0;
      @(negedge Clk);
    end
  endtask

  initial begin
    Reset_n = 1'b0;
    DrawX = '0;
    DrawY = '0;
    pix_valid_in = 1'b0;
    frame_start = 1'b0;
    level_index = 3'd0;
    repeat (3) @(negedge Clk);
    check("reset data", data_Out_background, 24'h000000);
    check("reset valid", 24'(pix_valid_out), 24'h0);
    check("reset busy", 24'(fade_busy), 24'h0);
    check("reset level", 24'(level_active), 24'h0);
    Reset_n = 1'b1;

    // Region classes at level 0, full brightness.
    check_pixel("path (100,300)", 10'd100, 10'd300, 24'h808080);
    check("valid out", 24'(pix_valid_out), 24'h1);
    check_pixel("banner_in (300,20)", 10'd300, 10'd20, 24'he9bf2f);
    check_pixel("banner_out (300,70)", 10'd300, 10'd70, 24'hfdeca6);
    check_pixel("field (600,450)", 10'd600, 10'd450, 24'ha6e0fd);

    // Negative X differences must square correctly.
    check_pixel("signed (20,10)", 10'd20, 10'd10, 24'hfdeca6);
    check_pixel("signed (0,79)", 10'd0, 10'd79, 24'ha6e0fd);

    // Level 0 -> 1 fade.
    @(negedge Clk);
    level_index = 3'd1;
    @(negedge Clk);
    check("fade_busy rises", 24'(fade_busy), 24'h1);
    frames(16);
    check_pixel("field alpha8", 10'd600, 10'd450, 24'h53707e);
    frames(15);
    check("level after 31", 24'(level_active), 24'h0);
    frames(1);
    check("level after 32", 24'(level_active), 24'h1);
    check_pixel("field alpha0", 10'd600, 10'd450, 24'h000000);
    check_pixel("path alpha0", 10'd100, 10'd300, 24'h000000);
    frames(31);
    check("busy after 63", 24'(fade_busy), 24'h1);
    frames(1);
    check("busy after 64", 24'(fade_busy), 24'h0);
    check_pixel("field level1", 10'd600, 10'd450, 24'hc0c0c0);

    // Redirect during FADE_IN at alpha 5.
    @(negedge Clk);
    level_index = 3'd0;
    frames(32);
    check("level back to 0", 24'(level_active), 24'h0);
    frames(10);
    check_pixel("field alpha5", 10'd600, 10'd450, 24'h33464f);
    @(negedge Clk);
    level_index = 3'd2;
    @(negedge Clk);
    check("redirect busy", 24'(fade_busy), 24'h1);
    frames(2);
    check_pixel("resume alpha4", 10'd600, 10'd450, 24'h29383f);
    frames(7);
    check("level after 9", 24'(level_active), 24'h0);
    frames(1);
    check("level after 10", 24'(level_active), 24'h2);
    frames(32);
    check("busy idle lvl2", 24'(fade_busy), 24'h0);
    check_pixel("field level2", 10'd600, 10'd450, 24'h0ed145);

    // Out-of-range level.
    @(negedge Clk);
    level_index = 3'd5;
    frames(64);
    check("level 5 active", 24'(level_active), 24'h5);
    check_pixel("field level5", 10'd600, 10'd450, 24'hffffff);
    check_pixel("path level5", 10'd100, 10'd300, 24'h808080);

    // Asynchronous reset mid-fade at alpha 3.
    @(negedge Clk);
    level_index = 3'd0;
    frames(26);
    check_pixel("field alpha3", 10'd600, 10'd450, 24'h2f2f2f);
    #2;
    Reset_n = 1'b0;
    #1;
    check("async busy", 24'(fade_busy), 24'h0);
    check("async level", 24'(level_active), 24'h0);
    check("async data", data_Out_background, 24'h000000);
    check("async valid", 24'(pix_valid_out), 24'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    check_pixel("post reset field", 10'd600, 10'd450, 24'ha6e0fd);
    check("post reset busy", 24'(fade_busy), 24'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
